// File: rtl/apb_pwm_multi_pkg.sv
// apb_pwm_multi_pkg: register word offsets, control/status bit positions and unmapped read value
package apb_pwm_multi_pkg;
  localparam logic [17:0] A_CTRL = 18'h00;
  localparam logic [17:0] A_PRE = 18'h01;
  localparam logic [17:0] A_PERIOD = 18'h02;
  localparam logic [17:0] A_STATUS = 18'h03;
  localparam logic [17:0] A_IM = 18'h04;
  localparam logic [17:0] A_POL = 18'h05;
  localparam logic [17:0] A_CNT = 18'h06;
  localparam logic [17:0] A_CMP = 18'h08;
  localparam int CTRL_EN = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_CLR = 2;
  localparam int STATUS_WRAP = 0;
  localparam logic [31:0] RD_DEFAULT = 32'hDEADBEEF;
endpackage

// File: rtl/apb_pwm_multi_if.sv
// apb_pwm_multi_if: APB bus bundle with master and slave views
interface apb_pwm_multi_if;
  logic PSEL;
  logic [19:2] PADDR;
  logic PENABLE;
  logic PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic PREADY;
  modport master (output PSEL, PADDR, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY);
  modport slave (input PSEL, PADDR, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: shadowed compare against the shared counter driving a registered, polarity-adjusted output
module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic load_i,
  input  logic en_i,
  input  logic pol_i,
  input  logic [CNT_W-1:0] cmp_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic pwm_o
);
  logic [CNT_W-1:0] cmp_sh_q, cmp_sh_d;
  logic pwm_q, pwm_d;
  assign cmp_sh_d = load_i ? cmp_i : cmp_sh_q;
  assign pwm_d = (en_i && cnt_i < cmp_sh_q) ^ pol_i;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cmp_sh_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cmp_sh_q <= cmp_sh_d;
      pwm_q <= pwm_d;
    end
  assign pwm_o = pwm_q;
endmodule

// File: rtl/apb_pwm_multi.sv
// apb_pwm_multi: multi-channel APB PWM timer with prescaler, shadowed period/compare, one-shot and wrap irq
module apb_pwm_multi
  import apb_pwm_multi_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CNT_W = 16,
  parameter int PRE_W = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  apb_pwm_multi_if.slave apb,
  output logic [NCH-1:0] pwm_o,
  output logic irq_o
);
  logic [17:0] addr;
  logic wr, wr_ctrl, wr_status, en_rise, clr, tick, wrap, load, hit_cmp, unused_ok;
  logic en_q, en_d, oneshot_q, wrap_q, wrap_d, im_q, irq_q;
  logic [PRE_W-1:0] pre_q, pc_q, pc_d;
  logic [CNT_W-1:0] period_q, period_sh_q, cnt_q, cnt_d, rd_cmp;
  logic [NCH-1:0] pol_q;
  logic [CNT_W-1:0] cmp_q [NCH];
  assign addr = apb.PADDR;
  assign wr = apb.PSEL & apb.PWRITE & apb.PENABLE;
  assign wr_ctrl = wr && addr == A_CTRL;
  assign wr_status = wr && addr == A_STATUS;
  assign en_rise = wr_ctrl && !en_q && apb.PWDATA[CTRL_EN];
  assign clr = wr_ctrl && apb.PWDATA[CTRL_CLR];
  assign tick = en_q && pc_q == pre_q;
  assign wrap = tick && cnt_q == period_sh_q;
  assign load = wrap || en_rise;
  assign en_d = wr_ctrl ? apb.PWDATA[CTRL_EN] : en_q && !(wrap && oneshot_q);
  assign wrap_d = wrap || (wrap_q && !(wr_status && apb.PWDATA[STATUS_WRAP]));
  assign pc_d = (!en_q || !en_d || clr || tick) ? '0 : pc_q + 1'b1;
  assign cnt_d = (!en_q || !en_d || clr) ? '0 : !tick ? cnt_q : wrap ? '0 : cnt_q + 1'b1;
  assign unused_ok = ^apb.PWDATA;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      en_q <= 1'b0;
      oneshot_q <= 1'b0;
      pre_q <= '0;
      period_q <= '0;
      period_sh_q <= '0;
      wrap_q <= 1'b0;
      im_q <= 1'b0;
      pol_q <= '0;
      pc_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
      for (int i = 0; i < NCH; i++) cmp_q[i] <= '0;
    end else begin
      en_q <= en_d;
      if (wr_ctrl) oneshot_q <= apb.PWDATA[CTRL_ONESHOT];
      if (wr && addr == A_PRE) pre_q <= apb.PWDATA[PRE_W-1:0];
      if (wr && addr == A_PERIOD) period_q <= apb.PWDATA[CNT_W-1:0];
      if (wr && addr == A_IM) im_q <= apb.PWDATA[0];
      if (wr && addr == A_POL) pol_q <= apb.PWDATA[NCH-1:0];
      for (int i = 0; i < NCH; i++) if (wr && addr == A_CMP + 18'(i)) cmp_q[i] <= apb.PWDATA[CNT_W-1:0];
      if (load) period_sh_q <= period_q;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      wrap_q <= wrap_d;
      irq_q <= wrap_q & im_q;
    end
  always_comb begin
    rd_cmp = '0;
    hit_cmp = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (addr == A_CMP + 18'(i)) begin
        rd_cmp = cmp_q[i];
        hit_cmp = 1'b1;
      end
  end
  assign apb.PRDATA = addr == A_CTRL ? 32'({oneshot_q, en_q}) :
                      addr == A_PRE ? 32'(pre_q) :
                      addr == A_PERIOD ? 32'(period_q) :
                      addr == A_STATUS ? 32'(wrap_q) :
                      addr == A_IM ? 32'(im_q) :
                      addr == A_POL ? 32'(pol_q) :
                      addr == A_CNT ? 32'(cnt_q) :
                      hit_cmp ? 32'(rd_cmp) : RD_DEFAULT;
  assign apb.PREADY = 1'b1;
  assign irq_o = irq_q;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .load_i(load),
      .en_i(en_q),
      .pol_i(pol_q[c]),
      .cmp_i(cmp_q[c]),
      .cnt_i(cnt_q),
      .pwm_o(pwm_o[c])
    );
  end
endmodule

// File: tb/tb_apb_pwm_multi.sv
// tb_apb_pwm_multi: directed self-checking bench for apb_pwm_multi
module tb_apb_pwm_multi;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic [3:0] pwm;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  apb_pwm_multi_if apb();
  apb_pwm_multi #(.NCH(4), .CNT_W(16), .PRE_W(16)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .apb(apb),
    .pwm_o(pwm),
    .irq_o(irq)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [17:0] a, input logic [31:0] d);
    @(posedge PCLK);
    #1;
    apb.PSEL = 1'b1;
    apb.PWRITE = 1'b1;
    apb.PENABLE = 1'b0;
    apb.PADDR = a;
    apb.PWDATA = d;
    @(posedge PCLK);
    #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0;
  endtask
  task automatic rd(input logic [17:0] a, output logic [31:0] d);
    apb.PSEL = 1'b1;
    apb.PWRITE = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PADDR = a;
    #1;
    d = apb.PRDATA;
    apb.PSEL = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [17:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask
  initial begin
    logic [31:0] d;
    logic [29:0] pat, exp_pat;
    logic [19:0] pat1;
    logic [2:0] other;
    logic acc, all;
    apb.PSEL = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE = 1'b0;
    apb.PADDR = '0;
    apb.PWDATA = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_irq", 32'(irq), 0);
    PRESETn = 1'b1;
    for (int a = 0; a < 12; a++) if (a != 7) rdchk($sformatf("rst_reg%0d", a), 18'(a), 32'h0);
    rdchk("unmapped_07", 18'h7, 32'hDEADBEEF);
    rdchk("unmapped_0c", 18'hc, 32'hDEADBEEF);
    chk("pready", 32'(apb.PREADY), 1);
    wr(18'h1, 0);
    wr(18'h2, 9);
    wr(18'h8, 3);
    wr(18'h4, 1);
    wr(18'h0, 1);
    @(negedge PCLK);
    rdchk("duty_cnt_start", 18'h6, 0);
    chk("duty_pwm_start", 32'(pwm[0]), 0);
    other = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge PCLK);
      pat[k-1] = pwm[0];
      other |= pwm[3:1];
      exp_pat[k-1] = (k - 1) % 10 < 3;
      if (k == 5) rdchk("status_before_wrap", 18'h3, 0);
    end
    chk("duty_pattern", 32'(pat), 32'(exp_pat));
    chk("duty_high_count", $countones(pat), 9);
    chk("duty_idle_channels", 32'(other), 0);
    rdchk("status_wrap", 18'h3, 1);
    chk("irq_set", 32'(irq), 1);
    wr(18'h3, 1);
    rdchk("status_w1c", 18'h3, 0);
    repeat (2) @(negedge PCLK);
    chk("irq_cleared", 32'(irq), 0);
    wr(18'h0, 0);
    wr(18'h1, 2);
    wr(18'h2, 4);
    wr(18'h9, 2);
    wr(18'h0, 1);
    @(negedge PCLK);
    chk("pre_pwm_start", 32'(pwm[1]), 0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge PCLK);
      pat[k-1] = pwm[1];
      exp_pat[k-1] = k <= 6 || (k >= 16 && k <= 27);
      if (k == 3) begin
        apb.PSEL = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR = 18'h9;
        apb.PWDATA = 4;
      end
      if (k == 4) apb.PENABLE = 1'b1;
      if (k == 5) begin
        apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE = 1'b0;
      end
    end
    chk("shadow_first_period", $countones(pat[14:0]), 6);
    chk("shadow_second_period", $countones(pat[29:15]), 12);
    chk("shadow_pattern", 32'(pat), 32'(exp_pat));
    wr(18'h0, 0);
    wr(18'h1, 0);
    wr(18'h2, 4);
    wr(18'ha, 0);
    wr(18'hb, 5);
    wr(18'h5, 0);
    wr(18'h0, 1);
    @(negedge PCLK);
    acc = 1'b0;
    all = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge PCLK);
      acc |= pwm[2];
      all &= pwm[3];
    end
    chk("cmp_zero_low", 32'(acc), 0);
    chk("cmp_above_period_high", 32'(all), 1);
    wr(18'h5, 8);
    @(negedge PCLK);
    acc = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge PCLK);
      acc |= pwm[3];
    end
    chk("pol_inverted_low", 32'(acc), 0);
    wr(18'h0, 0);
    wr(18'h2, 0);
    wr(18'h8, 1);
    wr(18'h5, 0);
    wr(18'h0, 1);
    @(negedge PCLK);
    all = 1'b1;
    d = 0;
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] c;
      @(negedge PCLK);
      all &= pwm[0];
      rd(18'h6, c);
      d |= c;
    end
    chk("period0_pwm_high", 32'(all), 1);
    chk("period0_cnt_zero", d, 0);
    wr(18'h3, 1);
    rdchk("status_set_wins", 18'h3, 1);
    wr(18'h0, 0);
    wr(18'h3, 1);
    rdchk("status_cleared_idle", 18'h3, 0);
    wr(18'h2, 5);
    wr(18'h8, 2);
    wr(18'h5, 2);
    wr(18'h0, 3);
    @(negedge PCLK);
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      pat1[k-1] = pwm[0];
    end
    chk("oneshot_pattern", 32'(pat1), 32'h3);
    rdchk("oneshot_ctrl", 18'h0, 2);
    rdchk("oneshot_cnt", 18'h6, 0);
    chk("oneshot_pwm_pol", 32'(pwm), 32'h2);
    rdchk("oneshot_status", 18'h3, 1);
    wr(18'h2, 20);
    wr(18'h5, 1);
    wr(18'h0, 1);
    @(negedge PCLK);
    for (int k = 1; k <= 11; k++) begin
      @(negedge PCLK);
      if (k == 6) begin
        rdchk("clr_cnt_before", 18'h6, 6);
        apb.PSEL = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PADDR = 18'h0;
        apb.PWDATA = 5;
      end
      if (k == 7) apb.PENABLE = 1'b1;
      if (k == 8) begin
        apb.PSEL = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE = 1'b0;
        rdchk("clr_cnt_zero", 18'h6, 0);
        rdchk("clr_en_kept", 18'h0, 1);
      end
      if (k == 9) rdchk("clr_cnt_resume", 18'h6, 1);
    end
    rdchk("mid_cnt3", 18'h6, 3);
    chk("mid_pwm", 32'(pwm), 32'hb);
    chk("mid_irq", 32'(irq), 1);
    PRESETn = 1'b0;
    #1;
    chk("async_rst_pwm", 32'(pwm), 0);
    chk("async_rst_irq", 32'(irq), 0);
    rdchk("async_rst_ctrl", 18'h0, 0);
    rdchk("async_rst_cnt", 18'h6, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
